// File: rtl/aion_guard_pkg.sv
// Shared types and width helpers for the Guardian scram interlock.
// Also carries the Q16.16 sample type used by the telemetry buses.
package aion_burn_types_v1;

  typedef logic signed [31:0] q16_16_t;

endpackage

package aion_guard_pkg;

  typedef aion_burn_types_v1::q16_16_t q16_16_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } guard_state_e;

  // Bits needed to hold 0..max_v inclusive.
  function automatic int cnt_w(input int unsigned max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

  // Bits needed for a channel index (minimum 1).
  function automatic int idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEBOUNCE_DEF   = 3;
  localparam int STALE_CYC_DEF  = 1024;
  localparam int DEBOUNCE_W_DEF = cnt_w(DEBOUNCE_DEF);
  localparam int STALE_W_DEF    = cnt_w(STALE_CYC_DEF);

endpackage

// File: rtl/aion_guard_channel.sv
// One Guardian channel: signed limit compare, excursion debounce,
// arm-qualification flag and optional stale watchdog.
// Ports: clk/rst, data_i/valid_i sample, lo_i/hi_i limits, idle_i;
// trip_now_o, stale_now_o, cnt_zero_o, seen_ok_o status.
// Watchdog present only with AION_GUARD_STALE_WDOG_EN defined.
module aion_guard_channel
  import aion_guard_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEBOUNCE  = 3,
  parameter int STALE_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic              idle_i,
  output logic              trip_now_o,
  output logic              stale_now_o,
  output logic              cnt_zero_o,
  output logic              seen_ok_o
);

  localparam int EW = cnt_w(DEBOUNCE);
  localparam logic [EW-1:0] DB = EW'(DEBOUNCE);

  logic [EW-1:0] exc_q, exc_d;
  logic          seen_q, seen_d;
  logic          oor, ok_now;

  assign oor = ($signed(data_i) < $signed(lo_i)) ||
               ($signed(data_i) > $signed(hi_i));
  assign ok_now = valid_i & ~oor;

  always_comb begin
    exc_d = exc_q;
    if (valid_i) begin
      if (!oor)            exc_d = '0;
      else if (exc_q == DB) exc_d = DB;
      else                 exc_d = exc_q + 1'b1;
    end
  end

  // A saturated counter keeps re-asserting the trip on each further
  // out-of-range sample, which is what blocks a premature clear.
  assign trip_now_o = valid_i & oor & (exc_d == DB);
  assign cnt_zero_o = (exc_q == '0);

  // Arm qualification only accumulates while the FSM sits in IDLE.
  assign seen_d    = idle_i & (seen_q | ok_now);
  assign seen_ok_o = seen_q | ok_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      exc_q  <= exc_d;
      seen_q <= seen_d;
    end
  end

`ifdef AION_GUARD_STALE_WDOG_EN
  localparam int SW = cnt_w(STALE_CYC);
  localparam logic [SW-1:0] SL = SW'(STALE_CYC);

  logic [SW-1:0] stale_q, stale_d;

  always_comb begin
    stale_d = stale_q;
    if (valid_i)           stale_d = '0;
    else if (stale_q != SL) stale_d = stale_q + 1'b1;
  end

  assign stale_now_o = ~valid_i & (stale_d == SL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stale_q <= '0;
    else     stale_q <= stale_d;
  end
`else
  assign stale_now_o = 1'b0;
`endif

endmodule

// File: rtl/aion_guardian_scram_array.sv
// Multi-channel Guardian interlock with latched fail-safe scram_alarm.
// Ports: clk/rst, ch_data/ch_valid, lim_lo/lim_hi, clear_req in;
// scram_alarm, trip_cause, stale_cause, first_ch, state out.
// Optional stale watchdog: define AION_GUARD_STALE_WDOG_EN.
module aion_guardian_scram_array
  import aion_guard_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int DEBOUNCE  = 3,
  parameter int STALE_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*DATA_W-1:0]   lim_lo,
  input  logic [N_CH*DATA_W-1:0]   lim_hi,
  input  logic                     clear_req,
  output logic                     scram_alarm,
  output logic [N_CH-1:0]          trip_cause,
  output logic [N_CH-1:0]          stale_cause,
  output logic [idx_w(N_CH)-1:0]   first_ch,
  output logic [1:0]               state
);

  localparam int FW = idx_w(N_CH);

  logic [1:0]             state_q, state_d;
  logic                   alarm_q, alarm_d;
  logic [N_CH-1:0]        trip_q, trip_d;
  logic [N_CH-1:0]        stale_q, stale_d;
  logic [FW-1:0]          first_q, first_d;
  logic [N_CH*DATA_W-1:0] lo_q, hi_q;
  logic [N_CH*DATA_W-1:0] lo_use, hi_use;
  logic                   cap;

  logic [N_CH-1:0] trip_now, stale_now, cnt_zero, seen_ok;
  logic            idle, arm_ok, any_hit, clr_ok;
  logic [FW-1:0]   first_enc;

  assign idle = (state_q == IDLE);

  // Limits are not yet captured in IDLE, so arm qualification
  // checks samples against the live limit inputs.
  assign lo_use = idle ? lim_lo : lo_q;
  assign hi_use = idle ? lim_hi : hi_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aion_guard_channel #(
      .DATA_W   (DATA_W),
      .DEBOUNCE (DEBOUNCE),
      .STALE_CYC(STALE_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .data_i     (ch_data[i*DATA_W +: DATA_W]),
      .valid_i    (ch_valid[i]),
      .lo_i       (lo_use[i*DATA_W +: DATA_W]),
      .hi_i       (hi_use[i*DATA_W +: DATA_W]),
      .idle_i     (idle),
      .trip_now_o (trip_now[i]),
      .stale_now_o(stale_now[i]),
      .cnt_zero_o (cnt_zero[i]),
      .seen_ok_o  (seen_ok[i])
    );
  end

  assign arm_ok  = &seen_ok;
  assign any_hit = |(trip_now | stale_now);
  assign clr_ok  = clear_req & (&cnt_zero) & ~any_hit;

  always_comb begin
    first_enc = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (trip_now[i] | stale_now[i]) first_enc = FW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_ok)  state_d = ARMED;
      ARMED:   if (any_hit) state_d = TRIPPED;
      TRIPPED: if (clr_ok)  state_d = ARMED;
      default: state_d = TRIPPED;
    endcase
  end

  always_comb begin
    trip_d  = trip_q;
    stale_d = stale_q;
    first_d = first_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: cap = arm_ok;
      ARMED: begin
        if (any_hit) begin
          trip_d  = trip_q | trip_now;
          stale_d = stale_q | stale_now;
          first_d = first_enc;
        end
      end
      TRIPPED: begin
        if (clr_ok) begin
          trip_d  = '0;
          stale_d = '0;
          cap     = 1'b1;
        end else begin
          trip_d  = trip_q | trip_now;
          stale_d = stale_q | stale_now;
        end
      end
      default: ;
    endcase
    alarm_d = (state_d != ARMED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b1;
      trip_q  <= '0;
      stale_q <= '0;
      first_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      alarm_q <= alarm_d;
      trip_q  <= trip_d;
      stale_q <= stale_d;
      first_q <= first_d;
      if (cap) begin
        lo_q <= lim_lo;
        hi_q <= lim_hi;
      end
    end
  end

  assign scram_alarm = alarm_q;
  assign trip_cause  = trip_q;
  assign stale_cause = stale_q;
  assign first_ch    = first_q;
  assign state       = state_q;

endmodule

// File: tb/tb_aion_guardian_scram_array.sv
// Bench for aion_guardian_scram_array: directed plan plus random
// traffic checked against a behavioural interlock model.
module tb_aion_guardian_scram_array;

  localparam int N  = 4;
  localparam int DB = 3;
  localparam int SC = 16;
  localparam int ONE = 32'h0001_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*32-1:0] ch_data = '0;
  logic [N-1:0]   ch_valid = '0;
  logic [N*32-1:0] lim_lo = '0;
  logic [N*32-1:0] lim_hi = '0;
  logic           clear_req = 1'b0;
  logic           scram_alarm;
  logic [N-1:0]   trip_cause;
  logic [N-1:0]   stale_cause;
  logic [1:0]     first_ch;
  logic [1:0]     state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aion_guardian_scram_array #(
    .N_CH(N), .DATA_W(32), .DEBOUNCE(DB), .STALE_CYC(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_data(ch_data), .ch_valid(ch_valid),
    .lim_lo(lim_lo), .lim_hi(lim_hi),
    .clear_req(clear_req),
    .scram_alarm(scram_alarm),
    .trip_cause(trip_cause), .stale_cause(stale_cause),
    .first_ch(first_ch), .state(state)
  );

  // Behavioural model: 0=IDLE 1=ARMED 2=TRIPPED
  int       m_state;
  int       m_cnt[N];
  int       m_stc[N];
  bit       m_seen[N];
  int       m_lo[N];
  int       m_hi[N];
  bit [N-1:0] m_trip;
  bit [N-1:0] m_stale;
  int       m_first;

  task automatic m_reset();
    m_state = 0;
    m_trip  = '0;
    m_stale = '0;
    m_first = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_stc[i] = 0; m_seen[i] = 0;
      m_lo[i] = 0;  m_hi[i] = 0;
    end
  endtask

  task automatic m_capture();
    for (int i = 0; i < N; i++) begin
      m_lo[i] = lim_lo[i*32 +: 32];
      m_hi[i] = lim_hi[i*32 +: 32];
    end
  endtask

  // Advance model by one clock using the currently driven inputs.
  task automatic m_step();
    bit [N-1:0] tr;
    bit [N-1:0] st;
    bit all_zero;
    bit all_seen;
    int x, lo, hi, f;
    bit out;
    tr = '0; st = '0; all_zero = 1; all_seen = 1;
    for (int i = 0; i < N; i++) begin
      x  = ch_data[i*32 +: 32];
      lo = (m_state == 0) ? int'(lim_lo[i*32 +: 32]) : m_lo[i];
      hi = (m_state == 0) ? int'(lim_hi[i*32 +: 32]) : m_hi[i];
      out = (x < lo) || (x > hi);
      if (m_cnt[i] != 0) all_zero = 0;
      if (ch_valid[i]) begin
        if (out) begin
          m_cnt[i] = (m_cnt[i] + 1 > DB) ? DB : m_cnt[i] + 1;
          if (m_cnt[i] == DB) tr[i] = 1;
        end else begin
          m_cnt[i] = 0;
          m_seen[i] = 1;
        end
      end
`ifdef AION_GUARD_STALE_WDOG_EN
      if (ch_valid[i]) m_stc[i] = 0;
      else if (m_stc[i] < SC) m_stc[i]++;
      if (!ch_valid[i] && m_stc[i] == SC) st[i] = 1;
`endif
      if (!m_seen[i]) all_seen = 0;
    end
    f = 0;
    for (int i = N - 1; i >= 0; i--) if (tr[i] || st[i]) f = i;
    if (m_state == 0) begin
      if (all_seen) begin
        m_state = 1;
        m_capture();
        for (int i = 0; i < N; i++) m_seen[i] = 0;
      end
    end else if (m_state == 1) begin
      if ((tr | st) != 0) begin
        m_state = 2;
        m_trip  |= tr;
        m_stale |= st;
        m_first = f;
      end
    end else begin
      if (clear_req && all_zero && (tr | st) == 0) begin
        m_state = 1;
        m_trip  = '0;
        m_stale = '0;
        m_capture();
      end else begin
        m_trip  |= tr;
        m_stale |= st;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".alarm"}, 32'(scram_alarm), 32'(m_state != 1));
    chk({tag, ".trip"},  32'(trip_cause), 32'(m_trip));
    chk({tag, ".stale"}, 32'(stale_cause), 32'(m_stale));
    chk({tag, ".first"}, 32'(first_ch), 32'(m_first));
  endtask

  // Drive at negedge, model, clock, compare 1 time unit after posedge.
  task automatic step(input logic [N-1:0] v, input logic clr,
                      input string tag);
    @(negedge clk);
    ch_valid  = v;
    clear_req = clr;
    #1;
    m_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic set_all(input int val);
    for (int i = 0; i < N; i++) ch_data[i*32 +: 32] = val;
  endtask

  task automatic set_ch(input int i, input int val);
    ch_data[i*32 +: 32] = val;
  endtask

  initial begin
    int k;
    int x;
    for (int i = 0; i < N; i++) begin
      lim_lo[i*32 +: 32] = -2 * ONE;
      lim_hi[i*32 +: 32] =  2 * ONE;
    end
    set_all(ONE);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.alarm", 32'(scram_alarm), 32'd1);
    chk("rst.cause", 32'({trip_cause, stale_cause}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(4'b0001, 0, "arm0");
    step(4'b0010, 0, "arm1");
    step(4'b0100, 0, "arm2");
    chk("arm.pre_alarm", 32'(scram_alarm), 32'd1);
    step(4'b1000, 0, "arm3");
    chk("arm.armed", 32'(state), 32'd1);
    chk("arm.alarm0", 32'(scram_alarm), 32'd0);

    set_ch(2, 3 * ONE);
    step(4'b1111, 0, "t2a");
    step(4'b1011, 0, "t2gap");
    step(4'b1111, 0, "t2b");
    chk("t2.pre", 32'(scram_alarm), 32'd0);
    step(4'b1111, 0, "t2c");
    chk("t2.alarm", 32'(scram_alarm), 32'd1);
    chk("t2.cause", 32'(trip_cause), 32'b0100);
    chk("t2.first", 32'(first_ch), 32'd2);

    step(4'b1111, 1, "clr_blk");
    chk("clr_blk.state", 32'(state), 32'd2);
    set_ch(2, ONE);
    step(4'b1111, 0, "inrange");
    step(4'b1111, 1, "clr_ok");
    chk("clr_ok.alarm", 32'(scram_alarm), 32'd0);
    chk("clr_ok.cause", 32'(trip_cause), 32'd0);

    set_ch(1, -3 * ONE);
    set_ch(3, 3 * ONE);
    repeat (3) step(4'b1010, 0, "t13");
    chk("t13.cause", 32'(trip_cause), 32'b1010);
    chk("t13.first", 32'(first_ch), 32'd1);

    set_all(ONE);
    step(4'b1111, 0, "in2");
    step(4'b1111, 1, "clr2");
    set_ch(0, 3 * ONE);
    step(4'b0001, 0, "t0a");
    step(4'b0001, 0, "t0b");
    step(4'b0001, 1, "t0clr");
    chk("trip_wins", 32'(state), 32'd2);

    set_all(ONE);
    step(4'b1111, 0, "in3");
    step(4'b1111, 1, "clr3");
    repeat (SC + 2) step(4'b1110, 0, "stale");
`ifdef AION_GUARD_STALE_WDOG_EN
    chk("stale.cause", 32'(stale_cause), 32'b0001);
    chk("stale.alarm", 32'(scram_alarm), 32'd1);
`else
    chk("nostale.state", 32'(state), 32'd1);
`endif

    set_ch(0, 3 * ONE);
    repeat (3) step(4'b1111, 0, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("mid_rst.state", 32'(state), 32'd0);
    chk("mid_rst.alarm", 32'(scram_alarm), 32'd1);
    chk("mid_rst.cause", 32'(trip_cause), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        k = int'($urandom_range(0, 8)) - 4;
        x = k * ONE;
        if ($urandom_range(0, 3) == 0) x += int'($urandom_range(0, 2)) - 1;
        set_ch(i, x);
        lim_lo[i*32 +: 32] = -int'($urandom_range(1, 3)) * ONE;
        lim_hi[i*32 +: 32] =  int'($urandom_range(1, 3)) * ONE;
      end
      step(N'($urandom) | N'($urandom), $urandom_range(0, 3) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aion_guardian_scram_array.md
# aion_guardian_scram_array

Parametrised multi-channel Guardian interlock: compares N_CH signed Q16.16 telemetry channels against per-channel low/high limits, debounces excursions over consecutive valid samples, and drives a latched, fail-safe `scram_alarm`. It sits between the twin-bus telemetry sources (core thermal, edge geometry, and others) and the plant shutdown path. It replaces the single-channel, single-threshold, non-latching comparator.

## Interface
- `N_CH`, 4: number of monitored channels (1..16).
- `DATA_W`, 32: sample width; signed Q16.16 at 32.
- `DEBOUNCE`, 3: consecutive out-of-range valid samples required to trip (1..255).
- `STALE_CYC`, 1024: watchdog limit in cycles without a valid sample (only with the watchdog macro).
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_data`  in  N_CH*DATA_W  packed samples, channel i at bits [i*DATA_W +: DATA_W], signed.
- `ch_valid`  in  N_CH  per-channel sample strobe.
- `lim_lo`, `lim_hi`  in  N_CH*DATA_W each  signed limits; captured on arm only.
- `clear_req`  in  1  single-cycle operator reset request.
- `scram_alarm`  out  1  registered, latched trip output.
- `trip_cause`  out  N_CH  sticky per-channel limit-trip flags.
- `stale_cause`  out  N_CH  sticky per-channel watchdog flags; tied 0 without the macro.
- `first_ch`  out  $clog2(N_CH) (min 1)  index of the first tripping channel.
- `state`  out  2  FSM state encoding.

## Operation
- Out-of-range test is signed: `ch_data[i] < lim_lo_q[i]` or `ch_data[i] > lim_hi_q[i]`. Equality to a limit is in range.
- Per-channel excursion counter, updated only when `ch_valid[i]`:
  - Out-of-range sample: counter increments, saturating at DEBOUNCE.
  - In-range sample: counter clears to 0.
  - No valid strobe: counter holds.
- Channel limit-trip condition: a valid out-of-range sample that takes the counter to DEBOUNCE.
- FSM states: IDLE=0, ARMED=1, TRIPPED=2. Code 3 is illegal and recovers to TRIPPED.
  - IDLE: `scram_alarm`=1 (fail-safe). Goes to ARMED once every channel has delivered at least one valid in-range sample since entry. `lim_lo_q`/`lim_hi_q` are captured on the transition edge.
  - ARMED: `scram_alarm`=0. Any channel trip condition goes to TRIPPED, sets the matching `trip_cause` bits, and loads `first_ch` with the lowest tripping index.
  - TRIPPED: `scram_alarm`=1.
    - Further trips OR into `trip_cause`; `first_ch` is frozen.
    - `clear_req` is accepted only if every excursion counter is 0 and no trip or stale condition occurs that same cycle.
    - Accepting `clear_req` goes to ARMED, clears `trip_cause`/`stale_cause`, and recaptures the limits. Otherwise it is ignored.
- Simultaneous `clear_req` and a new trip in TRIPPED: the trip wins and the state stays TRIPPED.
- `clear_req` in IDLE or ARMED: no effect.
- Invalid-data channels never trip on limits. Only the watchdog covers silence.

## Timing
- Reset values:
  - `state`=IDLE, `scram_alarm`=1.
  - `trip_cause`=0, `stale_cause`=0, `first_ch`=0.
  - All counters 0, captured limits 0.
- Trip latency: `scram_alarm` rises on the clock edge that samples the DEBOUNCE-th consecutive out-of-range valid sample. It is visible one cycle after that sample is presented.
- Clear latency: `scram_alarm` falls on the edge that samples the accepted `clear_req`.
- Arm latency: ARMED is entered on the edge sampling the last required in-range sample.
- Reset mid-operation returns to IDLE with the alarm asserted. There is no bypass.

## Configuration
- `AION_GUARD_STALE_WDOG_EN` defined:
  - Each channel has a stale counter, reset to 0 on every `ch_valid[i]` and incremented otherwise, saturating at STALE_CYC.
  - In ARMED, a counter reaching STALE_CYC trips exactly like a limit trip, but sets `stale_cause[i]` and loads `first_ch`.
  - Counters run in every state. In TRIPPED a stale condition blocks clear.
- `AION_GUARD_STALE_WDOG_EN` undefined: no stale counters exist, `stale_cause` is constant 0, and STALE_CYC is unused.

## Structure
- Package `aion_guard_pkg`:
  - `guard_state_e` (IDLE/ARMED/TRIPPED).
  - Counter width localparams derived from DEBOUNCE/STALE_CYC.
  - Reuses `q16_16_t` from `aion_burn_types_v1`.
- Sub-module `aion_guard_channel`: one per channel via generate. It holds the excursion counter, the optional stale counter, and limit compare. It outputs `trip_now`, `stale_now`, `cnt_zero` and `seen_ok`.
- The top level holds the FSM, limit capture, sticky cause registers and the lowest-index priority encoder.

## Test plan
- Reset, then present in-range samples (0x0001_0000 within [-0x0002_0000, 0x0002_0000]) on all 4 channels -> alarm stays 1 until the last channel's first valid sample, then `state`=ARMED and alarm 0.
- Channel 2 presents 0x0003_0000 for 3 valid cycles with one invalid gap -> alarm rises after the 3rd valid sample; `trip_cause`=4'b0100, `first_ch`=2.
- Channels 1 and 3 hit the 3rd out-of-range sample on the same cycle -> `trip_cause`=4'b1010, `first_ch`=1.
- In TRIPPED, `clear_req` while channel 2 is still out of range -> ignored. After an in-range sample, `clear_req` -> ARMED, alarm 0, causes cleared. `clear_req` on the same cycle as a new trip -> stays TRIPPED.
- With `AION_GUARD_STALE_WDOG_EN` and STALE_CYC=16, withhold `ch_valid[0]` for 16 cycles in ARMED -> alarm 1, `stale_cause`=4'b0001. Without the macro -> no trip.
- Assert `rst` mid-TRIPPED -> immediate IDLE, alarm 1, causes 0.
